// File: rtl/m_divider_pkg.sv
// Shared definitions for the RV32M multi-cycle divider: operation and state
// encodings, M-extension funct3 codes and small arithmetic helpers.
package m_divider_pkg;

    localparam int XLEN_C = 32;

    // funct3[1:0] of the DIV/DIVU/REM/REMU group
    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    // Divider sequencer states
    typedef enum logic [1:0] {
        DIV_ST_IDLE = 2'b00,
        DIV_ST_CALC = 2'b01,
        DIV_ST_FIX  = 2'b10,
        DIV_ST_DONE = 2'b11
    } div_state_e;

    // Full funct3 codes of the M extension (decode side)
    localparam logic [2:0] INS_MUL    = 3'b000;
    localparam logic [2:0] INS_MULH   = 3'b001;
    localparam logic [2:0] INS_MULHSU = 3'b010;
    localparam logic [2:0] INS_MULHU  = 3'b011;
    localparam logic [2:0] INS_DIV    = 3'b100;
    localparam logic [2:0] INS_DIVU   = 3'b101;
    localparam logic [2:0] INS_REM    = 3'b110;
    localparam logic [2:0] INS_REMU   = 3'b111;

    // DIV and REM treat operands as two's complement
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    // REM and REMU return the remainder instead of the quotient
    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

    // Magnitude of a value; only negated when the operation is signed
    function automatic logic [XLEN_C-1:0] abs_val(input logic [XLEN_C-1:0] v,
                                                  input logic take_abs);
        logic [XLEN_C-1:0] r;
        if (take_abs && v[XLEN_C-1]) begin
            r = {XLEN_C{1'b0}} - v;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Two's complement negation
    function automatic logic [XLEN_C-1:0] neg_val(input logic [XLEN_C-1:0] v);
        return {XLEN_C{1'b0}} - v;
    endfunction

endpackage

// File: rtl/m_divider.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; holds the pipeline through stall_o and
// presents a registered result with a one-cycle valid_o pulse.
// Optional feature macro: M_DIV_EARLY_OUT_EN enables a one-cycle fast path
// for divide-by-zero, signed overflow and |dividend| < |divisor|.
module m_divider
    import m_divider_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      div_op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            flush_i,
    output logic [XLEN-1:0] result_o,
    output logic            valid_o,
    output logic            stall_o
);

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};

    // Registered state
    div_state_e      state_q,    state_d;
    logic [XLEN-1:0] quo_q,      quo_d;
    logic [XLEN-1:0] rem_q,      rem_d;
    logic [XLEN-1:0] divisor_q,  divisor_d;
    logic [XLEN-1:0] dividend_q, dividend_d;
    logic [4:0]      cnt_q,      cnt_d;
    logic [1:0]      op_q,       op_d;
    logic            neg_quo_q,  neg_quo_d;
    logic            neg_rem_q,  neg_rem_d;
    logic            div0_q,     div0_d;
    logic [XLEN-1:0] result_q,   result_d;
    logic            valid_q,    valid_d;

    // Operand decode at issue time
    logic            signed_in_s;
    logic            rem_in_s;
    logic            div0_in_s;
    logic [XLEN-1:0] abs_a_s;
    logic [XLEN-1:0] abs_b_s;
    logic            early_s;
    logic [XLEN-1:0] early_res_s;

    // Iteration and sign fix-up
    logic [XLEN:0]   rem33_s;
    logic [XLEN-1:0] fix_quo_s;
    logic [XLEN-1:0] fix_rem_s;

    assign signed_in_s = op_is_signed(div_op_i);
    assign rem_in_s    = op_is_rem(div_op_i);
    assign div0_in_s   = (divisor_i == ZERO);
    assign abs_a_s     = abs_val(dividend_i, signed_in_s);
    assign abs_b_s     = abs_val(divisor_i, signed_in_s);

`ifdef M_DIV_EARLY_OUT_EN
    logic ovf_s;
    logic small_s;

    // Signed overflow is the single case whose quotient does not fit
    assign ovf_s   = signed_in_s
                   & (dividend_i == {1'b1, {(XLEN-1){1'b0}}})
                   & (divisor_i == ALL_ONES);
    // Magnitude compare: quotient is zero, remainder is the dividend itself
    assign small_s = (abs_a_s < abs_b_s);
    assign early_s = div0_in_s | ovf_s | small_s;

    // Architecturally defined answers for the short-circuited cases
    always_comb begin
        if (div0_in_s) begin
            early_res_s = rem_in_s ? dividend_i : ALL_ONES;
        end else if (ovf_s) begin
            early_res_s = rem_in_s ? ZERO : {1'b1, {(XLEN-1){1'b0}}};
        end else begin
            early_res_s = rem_in_s ? dividend_i : ZERO;
        end
    end
`else
    assign early_s     = 1'b0;
    assign early_res_s = ZERO;
`endif

    // Shift-and-subtract step: trial subtract of the divisor from the
    // partial remainder extended by the next dividend bit
    always_comb begin
        rem33_s = {rem_q, quo_q[XLEN-1]} - {1'b0, divisor_q};
    end

    // Sign fix-up; divide-by-zero bypasses negation and returns the raw
    // dividend as remainder so both builds give the RISC-V values
    always_comb begin
        if (neg_quo_q && !div0_q) begin
            fix_quo_s = neg_val(quo_q);
        end else begin
            fix_quo_s = quo_q;
        end
        if (div0_q) begin
            fix_rem_s = dividend_q;
        end else if (neg_rem_q) begin
            fix_rem_s = neg_val(rem_q);
        end else begin
            fix_rem_s = rem_q;
        end
    end

    // Next-state and datapath update for the sequencer
    always_comb begin
        state_d    = state_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        divisor_d  = divisor_q;
        dividend_d = dividend_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        div0_d     = div0_q;
        result_d   = result_q;
        valid_d    = 1'b0;

        if (flush_i) begin
            state_d = DIV_ST_IDLE;
        end else begin
            case (state_q)
                DIV_ST_IDLE: begin
                    if (start_i) begin
                        op_d       = div_op_i;
                        dividend_d = dividend_i;
                        div0_d     = div0_in_s;
                        neg_quo_d  = signed_in_s & (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
                        neg_rem_d  = signed_in_s & dividend_i[XLEN-1];
                        if (early_s) begin
                            result_d = early_res_s;
                            valid_d  = 1'b1;
                            state_d  = DIV_ST_DONE;
                        end else begin
                            quo_d     = abs_a_s;
                            divisor_d = abs_b_s;
                            rem_d     = ZERO;
                            cnt_d     = 5'd31;
                            state_d   = DIV_ST_CALC;
                        end
                    end else begin
                        state_d = DIV_ST_IDLE;
                    end
                end
                DIV_ST_CALC: begin
                    if (!rem33_s[XLEN]) begin
                        rem_d = rem33_s[XLEN-1:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_d = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
                        quo_d = {quo_q[XLEN-2:0], 1'b0};
                    end
                    if (cnt_q == 5'd0) begin
                        state_d = DIV_ST_FIX;
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
                DIV_ST_FIX: begin
                    result_d = op_is_rem(op_q) ? fix_rem_s : fix_quo_s;
                    valid_d  = 1'b1;
                    state_d  = DIV_ST_DONE;
                end
                DIV_ST_DONE: begin
                    state_d = DIV_ST_IDLE;
                end
                default: begin
                    state_d = DIV_ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= DIV_ST_IDLE;
            quo_q      <= ZERO;
            rem_q      <= ZERO;
            divisor_q  <= ZERO;
            dividend_q <= ZERO;
            cnt_q      <= 5'd0;
            op_q       <= 2'b00;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div0_q     <= 1'b0;
            result_q   <= ZERO;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            divisor_q  <= divisor_d;
            dividend_q <= dividend_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            div0_q     <= div0_d;
            result_q   <= result_d;
            valid_q    <= valid_d;
        end
    end

    // Stall covers the accepting cycle so the operands stay put, then the
    // whole iteration; it drops in DONE so the pipeline captures the result
    always_comb begin
        stall_o = ((state_q == DIV_ST_IDLE) & start_i & ~flush_i)
                | (state_q == DIV_ST_CALC)
                | (state_q == DIV_ST_FIX);
    end

    assign result_o = result_q;
    assign valid_o  = valid_q;

endmodule

// File: tb/tb_m_divider.sv
// Scoreboard bench for m_divider: a driver issues divides and queues the
// expected result/latency from an arithmetic reference; a monitor pops and
// compares whenever valid_o is seen. Honours M_DIV_EARLY_OUT_EN.
module tb_m_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        valid;
    logic        stall;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          start_cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          stall_cnt = 0;
    logic [31:0] last_res = 32'h0;

    m_divider #(.XLEN(32)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .div_op_i   (op),
        .dividend_i (a),
        .divisor_i  (b),
        .flush_i    (flush),
        .result_o   (result),
        .valid_o    (valid),
        .stall_o    (stall)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: RISC-V division semantics from plain 64-bit arithmetic
    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] x,
                                               input logic [31:0] y);
        longint n, d, q, r;
        if (y == 32'h0) return o[1] ? x : 32'hFFFF_FFFF;
        if (o[0] == 1'b0) begin
            n = $signed(x);
            d = $signed(y);
        end else begin
            n = longint'({32'h0, x});
            d = longint'({32'h0, y});
        end
        q = n / d;
        r = n % d;
        return o[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic bit fast_path(input logic [1:0] o, input logic [31:0] x,
                                     input logic [31:0] y);
`ifdef M_DIV_EARLY_OUT_EN
        longint mx, my;
        if (o[0] == 1'b0) begin
            mx = $signed(x);
            my = $signed(y);
            if (mx < 0) mx = -mx;
            if (my < 0) my = -my;
        end else begin
            mx = longint'({32'h0, x});
            my = longint'({32'h0, y});
        end
        if (y == 32'h0) return 1'b1;
        if (o[0] == 1'b0 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1'b1;
        return (mx < my);
`else
        return 1'b0;
`endif
    endfunction

    // Monitor: count stall cycles of the pending op, compare on valid_o
    always @(negedge clk) begin
        #4;
        if (!rst) begin
            if (sb.size() != 0 && stall) stall_cnt++;
            if (valid) begin
                if (sb.size() == 0) begin
                    check("spurious_valid", {31'h0, valid}, 32'h0);
                end else begin
                    mon_e = sb.pop_front();
                    check("result", result, mon_e.res);
                    check("latency", cyc - mon_e.start_cyc, mon_e.lat);
                    check("stall_cycles", stall_cnt, mon_e.lat);
                end
                stall_cnt = 0;
            end
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        @(negedge clk);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        e.res       = ref_result(o, x, y);
        e.lat       = fast_path(o, x, y) ? 1 : 34;
        e.start_cyc = cyc;
        sb.push_back(e);
        last_res = e.res;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check("timeout", 32'(sb.size()), 32'h0);
            sb.delete();
            stall_cnt = 0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        a     = 32'h0;
        b     = 32'h0;
        #2;
        check("reset_result", result, 32'h0);
        check("reset_valid", {31'h0, valid}, 32'h0);
        check("reset_stall", {31'h0, stall}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed cases
        run_op(2'b01, 32'd100, 32'd7);
        run_op(2'b11, 32'd100, 32'd7);
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE);
        run_op(2'b00, 32'd5, 32'd0);
        run_op(2'b11, 32'd5, 32'd0);
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'b10, 32'hFFFF_FFFD, 32'd5);
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);

        // Randomized operand classes
        for (int k = 0; k < 24; k++) begin
            logic [31:0] x, y;
            logic [1:0]  o;
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 4))
                0: y = 32'h0;
                1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                2: y = 32'($urandom_range(1, 15));
                3: x = 32'($urandom_range(0, 100));
                default: ;
            endcase
            run_op(o, x, y);
        end

        // Flush in the middle of CALC
        @(negedge clk);
        op = 2'b01; a = 32'hFFFF_FFFF; b = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #4;
        check("flush_stall", {31'h0, stall}, 32'h0);
        check("flush_valid", {31'h0, valid}, 32'h0);
        check("flush_result_hold", result, last_res);
        repeat (40) @(negedge clk);
        run_op(2'b01, 32'd9, 32'd3);

        // Asynchronous reset in the middle of CALC
        @(negedge clk);
        op = 2'b01; a = 32'hFFFF_FFFF; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_stall", {31'h0, stall}, 32'h0);
        check("async_rst_valid", {31'h0, valid}, 32'h0);
        check("async_rst_result", result, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_op(2'b01, 32'd20, 32'd6);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
